// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register file's single write port among NREQ writeback
//   requesters (e.g. ALU, load unit, CSR unit). Valid/ready handshakes with
//   round-robin priority. The winning write is registered for one cycle and
//   drives the register file write port. Writes to x0 are consumed, dropped
//   and counted in a saturating 8-bit counter.
//
// Parameters
//   NREQ  number of requesters (2..4)
//   XLEN  data width
//   AW    register address width
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   hold         freeze the write port: no grants while high
//   req_valid    per-requester write request
//   req_ready    per-requester grant (one-hot or zero, combinational)
//   req_addr     packed destination addresses, requester i at [i*AW +: AW]
//   req_data     packed write data, requester i at [i*XLEN +: XLEN]
//   rf_we        registered write enable
//   rf_waddr     registered write address
//   rf_wdata     registered write data
//   grant_id     index of the last accepted requester (registered)
//   x0_drop_cnt  saturating count of accepted writes to x0
//
// Optional build macro WB_ARB_FWD_EN adds same-cycle forwarding of the
// in-flight write to two read addresses:
//   rd_a1, rd_a2               read addresses
//   fwd1_valid, fwd1_data      forward result for rd_a1
//   fwd2_valid, fwd2_data      forward result for rd_a2
module wb_port_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*XLEN-1:0] req_data,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic [1:0]           grant_id,
`ifdef WB_ARB_FWD_EN
    input  logic [AW-1:0]        rd_a1,
    input  logic [AW-1:0]        rd_a2,
    output logic                 fwd1_valid,
    output logic [XLEN-1:0]      fwd1_data,
    output logic                 fwd2_valid,
    output logic [XLEN-1:0]      fwd2_data,
`endif
    output logic [7:0]           x0_drop_cnt
);

    logic [1:0]      rr_ptr;
    logic            accept;
    logic [1:0]      win_idx;
    logic [1:0]      nxt_ptr;
    logic [AW-1:0]   win_addr;
    logic [XLEN-1:0] win_data;

    // Round-robin scan starting at rr_ptr. rr_ptr and the offset are both
    // below NREQ, so one conditional subtraction performs the modulo.
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        req_ready = '0;
        accept    = 1'b0;
        win_idx   = '0;
        sum       = '0;
        idx       = '0;
        if (rst && !hold) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                sum = {1'b0, rr_ptr} + 3'(k);
                if (sum >= 3'(NREQ))
                    sum = sum - 3'(NREQ);
                idx = sum[1:0];
                if (!accept && req_valid[idx]) begin
                    accept         = 1'b1;
                    win_idx        = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        win_addr = req_addr[int'(win_idx)*AW +: AW];
        win_data = req_data[int'(win_idx)*XLEN +: XLEN];
        if (win_idx == 2'(NREQ-1))
            nxt_ptr = '0;
        else
            nxt_ptr = win_idx + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr      <= '0;
            rf_we       <= 1'b0;
            rf_waddr    <= '0;
            rf_wdata    <= '0;
            grant_id    <= '0;
            x0_drop_cnt <= '0;
        end else if (accept) begin
            rr_ptr   <= nxt_ptr;
            rf_waddr <= win_addr;
            rf_wdata <= win_data;
            grant_id <= win_idx;
            rf_we    <= (win_addr != '0);
            if (win_addr == '0 && x0_drop_cnt != 8'hFF)
                x0_drop_cnt <= x0_drop_cnt + 8'd1;
        end else begin
            rf_we <= 1'b0;
        end
    end

`ifdef WB_ARB_FWD_EN
    always_comb begin
        fwd1_valid = rf_we && (rf_waddr == rd_a1) && (rd_a1 != '0);
        fwd2_valid = rf_we && (rf_waddr == rd_a2) && (rd_a2 != '0);
        fwd1_data  = fwd1_valid ? rf_wdata : '0;
        fwd2_data  = fwd2_valid ? rf_wdata : '0;
    end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    localparam logic [31:0] A0 = 32'hA0A0_0001;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] A2 = 32'hA2A2_0003;
    localparam logic [31:0] FF = 32'hFFFF_FFFF;

    localparam logic [14:0] ADDR_N  = {5'd3, 5'd5, 5'd1};
    localparam logic [14:0] ADDR_X0 = {5'd3, 5'd5, 5'd0};
    localparam logic [95:0] DATA_N  = {A2, DB, A0};
    localparam logic [95:0] DATA_X0 = {A2, DB, FF};

    logic                 clk;
    logic                 rst;
    logic                 hold;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*XLEN-1:0] req_data;
    logic                 rf_we;
    logic [AW-1:0]        rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic [1:0]           grant_id;
    logic [7:0]           x0_drop_cnt;
`ifdef WB_ARB_FWD_EN
    logic [AW-1:0]        rd_a1;
    logic [AW-1:0]        rd_a2;
    logic                 fwd1_valid;
    logic [XLEN-1:0]      fwd1_data;
    logic                 fwd2_valid;
    logic [XLEN-1:0]      fwd2_data;
`endif

    int total = 0;
    int bad   = 0;

    wb_port_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .hold        (hold),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .grant_id    (grant_id),
`ifdef WB_ARB_FWD_EN
        .rd_a1       (rd_a1),
        .rd_a2       (rd_a2),
        .fwd1_valid  (fwd1_valid),
        .fwd1_data   (fwd1_data),
        .fwd2_valid  (fwd2_valid),
        .fwd2_data   (fwd2_data),
`endif
        .x0_drop_cnt (x0_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        hold;
        logic [2:0]  valid;
        logic [14:0] addr;
        logic [95:0] data;
        logic [2:0]  exp_ready;
        logic        exp_we;
        logic [4:0]  exp_waddr;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_gid;
        logic [7:0]  exp_cnt;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic h, logic [2:0] v, logic x0,
                                logic [2:0] er, logic ew, logic [4:0] ea,
                                logic [31:0] ed, logic [1:0] eg, logic [7:0] ec);
        vec_t t;
        t.rst = r; t.hold = h; t.valid = v;
        t.addr = x0 ? ADDR_X0 : ADDR_N;
        t.data = x0 ? DATA_X0 : DATA_N;
        t.exp_ready = er; t.exp_we = ew; t.exp_waddr = ea;
        t.exp_wdata = ed; t.exp_gid = eg; t.exp_cnt = ec;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        // reset, requesters valid but must be gated
        tv.push_back(mk(0,0,3'b111,0, 3'b000,0,5'd0,32'h0,2'd0,8'd0));
        tv.push_back(mk(0,0,3'b111,0, 3'b000,0,5'd0,32'h0,2'd0,8'd0));
        // release: all valid -> 0,1,2,0,1,2
        tv.push_back(mk(1,0,3'b111,0, 3'b001,1,5'd1,A0,2'd0,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b010,1,5'd5,DB,2'd1,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b100,1,5'd3,A2,2'd2,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b001,1,5'd1,A0,2'd0,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b010,1,5'd5,DB,2'd1,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b100,1,5'd3,A2,2'd2,8'd0));
        // idle: outputs hold, we drops
        tv.push_back(mk(1,0,3'b000,0, 3'b000,0,5'd3,A2,2'd2,8'd0));
        // req0 and req2 only -> 0,2,0,2
        tv.push_back(mk(1,0,3'b101,0, 3'b001,1,5'd1,A0,2'd0,8'd0));
        tv.push_back(mk(1,0,3'b101,0, 3'b100,1,5'd3,A2,2'd2,8'd0));
        tv.push_back(mk(1,0,3'b101,0, 3'b001,1,5'd1,A0,2'd0,8'd0));
        tv.push_back(mk(1,0,3'b101,0, 3'b100,1,5'd3,A2,2'd2,8'd0));
        // single write from req1, then drop valid
        tv.push_back(mk(1,0,3'b010,0, 3'b010,1,5'd5,DB,2'd1,8'd0));
        tv.push_back(mk(1,0,3'b000,0, 3'b000,0,5'd5,DB,2'd1,8'd0));
        // x0 write from req0
        tv.push_back(mk(1,0,3'b001,1, 3'b001,0,5'd0,FF,2'd0,8'd1));
        // hold two cycles with 110 after grant to 0
        tv.push_back(mk(1,1,3'b110,1, 3'b000,0,5'd0,FF,2'd0,8'd1));
        tv.push_back(mk(1,1,3'b110,1, 3'b000,0,5'd0,FF,2'd0,8'd1));
        tv.push_back(mk(1,0,3'b110,1, 3'b010,1,5'd5,DB,2'd1,8'd1));
        // hold rises while a write is registered
        tv.push_back(mk(1,1,3'b110,1, 3'b000,0,5'd5,DB,2'd1,8'd1));
        tv.push_back(mk(1,0,3'b110,1, 3'b100,1,5'd3,A2,2'd2,8'd1));
        // reset while rf_we=1
        tv.push_back(mk(0,0,3'b111,0, 3'b000,0,5'd0,32'h0,2'd0,8'd0));
        tv.push_back(mk(1,0,3'b111,0, 3'b001,1,5'd1,A0,2'd0,8'd0));

        hold = 1'b0;
        rst  = 1'b0;
`ifdef WB_ARB_FWD_EN
        rd_a1 = '0;
        rd_a2 = '0;
`endif
        foreach (tv[i]) begin
            rst       = tv[i].rst;
            hold      = tv[i].hold;
            req_valid = tv[i].valid;
            req_addr  = tv[i].addr;
            req_data  = tv[i].data;
            #1;
            check($sformatf("v%0d ready", i), 32'(req_ready), 32'(tv[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d rf_we", i), 32'(rf_we), 32'(tv[i].exp_we));
            check($sformatf("v%0d rf_waddr", i), 32'(rf_waddr), 32'(tv[i].exp_waddr));
            check($sformatf("v%0d rf_wdata", i), rf_wdata, tv[i].exp_wdata);
            check($sformatf("v%0d grant_id", i), 32'(grant_id), 32'(tv[i].exp_gid));
            check($sformatf("v%0d x0_cnt", i), 32'(x0_drop_cnt), 32'(tv[i].exp_cnt));
        end

        // x0 saturation: counter restarted at the last reset, 300 x0 writes
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 3'b001;
        req_addr  = ADDR_X0;
        req_data  = DATA_X0;
        for (int n = 1; n <= 300; n++) begin
            #1;
            check($sformatf("sat%0d ready", n), 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            check($sformatf("sat%0d rf_we", n), 32'(rf_we), 32'd0);
            check($sformatf("sat%0d x0_cnt", n), 32'(x0_drop_cnt), (n > 255) ? 32'd255 : 32'(n));
        end

`ifdef WB_ARB_FWD_EN
        // write x7 = 0x1234 and read it back through both forward paths
        req_valid = 3'b001;
        req_addr  = {5'd3, 5'd5, 5'd7};
        req_data  = {A2, DB, 32'h0000_1234};
        rd_a1     = 5'd7;
        rd_a2     = 5'd7;
        #1;
        check("fwd pre valid1", 32'(fwd1_valid), 32'd0);
        @(posedge clk);
        #1;
        check("fwd rf_we", 32'(rf_we), 32'd1);
        check("fwd1_valid", 32'(fwd1_valid), 32'd1);
        check("fwd1_data", fwd1_data, 32'h0000_1234);
        check("fwd2_valid", 32'(fwd2_valid), 32'd1);
        check("fwd2_data", fwd2_data, 32'h0000_1234);
        // x0 write with rd_a1=0 never forwards
        req_addr = ADDR_X0;
        req_data = DATA_X0;
        rd_a1    = 5'd0;
        @(posedge clk);
        #1;
        check("fwd x0 valid1", 32'(fwd1_valid), 32'd0);
        check("fwd x0 data1", fwd1_data, 32'h0);
        req_valid = 3'b000;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
